avalon_m_burst_master: RTL and testbench
========================================

AVALON_M_BURST_MASTER -- requirements
Module: avalon_m_burst_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, Avalon address width.
REQ-002 SHALL have parameter DATA_W, default 1024, data width in bits; DATA_W/8 byteenable bits.
REQ-003 SHALL have parameter BURST_W, default 11, burstcount width.
REQ-004 SHALL have port: clk  in  1  single clock, all logic on posedge.
REQ-005 SHALL have port: arst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports: cmd_valid in 1, cmd_ready out 1, cmd_write in 1 (1=write, 0=read), cmd_address in ADDR_W, cmd_burstcount in BURST_W; command handshake.
REQ-007 SHALL have ports: wr_data in DATA_W, wr_valid in 1, wr_ready out 1; write-beat stream.
REQ-008 SHALL have ports: rd_data out DATA_W, rd_valid out 1; read-beat stream, no backpressure.
REQ-009 SHALL have Avalon-MM master ports: avm_address out ADDR_W, avm_byteenable out DATA_W/8, avm_chipselect out 1, avm_read out 1, avm_write out 1, avm_writedata out DATA_W, avm_burstcount out BURST_W, avm_beginbursttransfer out 1, avm_readdata in DATA_W, avm_waitrequest in 1, avm_readdatavalid in 1.
REQ-010 SHALL have ports: busy out 1 (state != IDLE), err out 1 (one-cycle error pulse).

Function
REQ-011 SHALL implement FSM states IDLE, RD_REQ, RD_DATA, WR_BURST; all Avalon outputs registered.
REQ-012 cmd_ready SHALL be 1 only in IDLE; command accepted on cmd_valid & cmd_ready.
REQ-013 Accepted command with cmd_burstcount=0 SHALL be discarded, err pulse next cycle, FSM stays IDLE.
REQ-014 Accepted read (burstcount N>=1): next cycle enter RD_REQ with avm_read=1, avm_chipselect=1, avm_address=cmd_address, avm_burstcount=N, avm_byteenable all ones.
REQ-015 avm_beginbursttransfer SHALL be 1 exactly on the first cycle of each burst request, 0 otherwise, even if waitrequest stalls.
REQ-016 In RD_REQ, all request signals SHALL hold stable while avm_waitrequest=1; on posedge with avm_waitrequest=0, deassert avm_read and go to RD_DATA.
REQ-017 In RD_REQ and RD_DATA, each avm_readdatavalid=1 cycle SHALL be a beat: rd_data<=avm_readdata, rd_valid<=1 the following cycle (latency 1), beat counter increments.
REQ-018 When the Nth read beat is counted, SHALL return to IDLE; cmd_ready=1 the cycle after rd_valid of last beat is registered.
REQ-019 avm_readdatavalid in IDLE or WR_BURST SHALL be ignored (no rd_valid) and pulse err.
REQ-020 Accepted write: enter WR_BURST; avm_address, avm_burstcount=N, avm_chipselect=1 held for whole burst.
REQ-021 wr_ready SHALL equal WR_BURST & (beats issued < N) & (!avm_write | !avm_waitrequest).
REQ-022 On wr_valid & wr_ready: next cycle avm_write=1, avm_writedata=wr_data; if no new beat and current beat accepted, avm_write<=0 (idle cycles within burst permitted).
REQ-023 Write beat completes on avm_write & !avm_waitrequest; avm_beginbursttransfer=1 with the first avm_write cycle only.
REQ-024 When Nth write beat completes, avm_write, avm_chipselect<=0 and return to IDLE next cycle.
REQ-025 Beat counters SHALL be BURST_W bits, no wrap; N=2^BURST_W-1 SHALL be supported.

Reset
REQ-026 On arst=1 at posedge: FSM IDLE, counters 0; cmd_ready=0 while arst=1; avm_read, avm_write, avm_chipselect, avm_beginbursttransfer, rd_valid, wr_ready, busy, err = 0; avm_address, avm_burstcount, avm_writedata, rd_data = 0; byteenable all ones.
REQ-027 Reset mid-burst SHALL abandon the burst; no further beats issued or forwarded; cmd_ready=1 first cycle after arst drops.

Verification
REQ-028 Read addr=0x100, N=4, waitrequest=1 for 2 cycles, readdatavalid on 4 non-consecutive cycles -> request held 3 cycles, beginbursttransfer 1 cycle, 4 rd_valid pulses each 1 cycle after readdatavalid, then IDLE.
REQ-029 Write addr=0x200, N=3, wr_valid gap after beat 1, waitrequest=1 on beat 2 -> 3 avm_write beats with data in order, beat 2 held stable, address/burstcount constant, IDLE after beat 3.
REQ-030 Command with burstcount=0 -> no avm_read/avm_write, err=1 for exactly one cycle, cmd_ready stays 1.
REQ-031 Stray readdatavalid in IDLE -> rd_valid stays 0, err pulse 1 cycle.
REQ-032 arst asserted after 2 of 4 read beats -> all outputs reset values next edge, later readdatavalid beats produce err only, new command accepted.
REQ-033 Back-to-back read N=1 then write N=1 with cmd_valid held -> second command accepted cycle after first completes, no overlap of avm_read and avm_write.

Source files
------------

// File: rtl/avalon_m_burst_master.sv
// Avalon-MM burst master: each accepted command becomes one read or write burst on the bus.
// Avalon outputs registered; read beats forwarded 1 cycle after readdatavalid; wr_ready follows waitrequest.
module avalon_m_burst_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 1024,
    parameter int BURST_W = 11
) (
    input  logic                clk,
    input  logic                arst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_address,
    input  logic [BURST_W-1:0]  cmd_burstcount,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                wr_valid,
    output logic                wr_ready,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic [ADDR_W-1:0]   avm_address,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic                avm_chipselect,
    output logic                avm_read,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic [BURST_W-1:0]  avm_burstcount,
    output logic                avm_beginbursttransfer,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_waitrequest,
    input  logic                avm_readdatavalid,
    output logic                busy,
    output logic                err
);
    typedef enum logic [1:0] {IDLE, RD_REQ, RD_DATA, WR_BURST} state_t;

    localparam logic [BURST_W-1:0] ONE = BURST_W'(1);

    state_t               state_q, state_d;
    logic [BURST_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [BURST_W-1:0]   wr_iss_q, wr_iss_d;
    logic [BURST_W-1:0]   wr_done_q, wr_done_d;
    logic [BURST_W-1:0]   bcnt_q, bcnt_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W/8-1:0]  be_q, be_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 cs_q, cs_d;
    logic                 read_q, read_d;
    logic                 write_q, write_d;
    logic                 bbt_q, bbt_d;
    logic                 rvld_q, rvld_d;
    logic                 err_q, err_d;

    logic cmd_acc, rd_beat, rd_last, wr_take, wr_last, wr_rdy, wr_push;

    assign cmd_ready = ~arst & (state_q == IDLE);
    assign cmd_acc   = cmd_valid & cmd_ready;
    assign rd_beat   = avm_readdatavalid & ((state_q == RD_REQ) | (state_q == RD_DATA));
    assign rd_last   = rd_beat & (rd_cnt_q + ONE == bcnt_q);
    assign wr_take   = (state_q == WR_BURST) & write_q & ~avm_waitrequest;
    assign wr_last   = wr_take & (wr_done_q + ONE == bcnt_q);
    // A new write beat may load only when the bus slot is empty or draining this cycle.
    assign wr_rdy    = ~arst & (state_q == WR_BURST) & (wr_iss_q < bcnt_q)
                     & (~write_q | ~avm_waitrequest);
    assign wr_push   = wr_valid & wr_rdy;

    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        wr_iss_d  = wr_iss_q;
        wr_done_d = wr_done_q;
        bcnt_d    = bcnt_q;
        addr_d    = addr_q;
        be_d      = '1;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        cs_d      = cs_q;
        read_d    = read_q;
        write_d   = write_q;
        bbt_d     = 1'b0;
        rvld_d    = rd_beat;
        err_d     = avm_readdatavalid & ((state_q == IDLE) | (state_q == WR_BURST));

        if (rd_beat) begin
            rdata_d  = avm_readdata;
            rd_cnt_d = rd_cnt_q + ONE;
        end

        case (state_q)
            IDLE: begin
                if (cmd_acc) begin
                    if (cmd_burstcount == '0) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d    = cmd_address;
                        bcnt_d    = cmd_burstcount;
                        cs_d      = 1'b1;
                        rd_cnt_d  = '0;
                        wr_iss_d  = '0;
                        wr_done_d = '0;
                        if (cmd_write) begin
                            state_d = WR_BURST;
                        end else begin
                            state_d = RD_REQ;
                            read_d  = 1'b1;
                            bbt_d   = 1'b1;
                        end
                    end
                end
            end
            RD_REQ: begin
                if (!avm_waitrequest) begin
                    read_d  = 1'b0;
                    state_d = RD_DATA;
                end
                if (rd_last) begin
                    read_d  = 1'b0;
                    cs_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            RD_DATA: begin
                if (rd_last) begin
                    cs_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            WR_BURST: begin
                if (wr_take) begin
                    wr_done_d = wr_done_q + ONE;
                    write_d   = 1'b0;
                end
                if (wr_push) begin
                    write_d  = 1'b1;
                    wdata_d  = wr_data;
                    wr_iss_d = wr_iss_q + ONE;
                    bbt_d    = (wr_iss_q == '0);
                end
                if (wr_last) begin
                    write_d = 1'b0;
                    cs_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q   <= IDLE;
            rd_cnt_q  <= '0;
            wr_iss_q  <= '0;
            wr_done_q <= '0;
            bcnt_q    <= '0;
            addr_q    <= '0;
            be_q      <= '1;
            wdata_q   <= '0;
            rdata_q   <= '0;
            cs_q      <= 1'b0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            bbt_q     <= 1'b0;
            rvld_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_iss_q  <= wr_iss_d;
            wr_done_q <= wr_done_d;
            bcnt_q    <= bcnt_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            cs_q      <= cs_d;
            read_q    <= read_d;
            write_q   <= write_d;
            bbt_q     <= bbt_d;
            rvld_q    <= rvld_d;
            err_q     <= err_d;
        end
    end

    assign wr_ready               = wr_rdy;
    assign rd_data                = rdata_q;
    assign rd_valid               = rvld_q;
    assign avm_address            = addr_q;
    assign avm_byteenable         = be_q;
    assign avm_chipselect         = cs_q;
    assign avm_read               = read_q;
    assign avm_write              = write_q;
    assign avm_writedata          = wdata_q;
    assign avm_burstcount         = bcnt_q;
    assign avm_beginbursttransfer = bbt_q;
    assign busy                   = (state_q != IDLE);
    assign err                    = err_q;

endmodule

// File: tb/tb_avalon_m_burst_master.sv
// Bench for avalon_m_burst_master: directed scenarios plus randomized bursts against a queue-based bus model.
module tb_avalon_m_burst_master;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          arst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_address;
    logic [BW-1:0] cmd_burstcount;
    logic [DW-1:0] wr_data;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [AW-1:0] avm_address;
    logic [DW/8-1:0] avm_byteenable;
    logic          avm_chipselect, avm_read, avm_write;
    logic [DW-1:0] avm_writedata;
    logic [BW-1:0] avm_burstcount;
    logic          avm_beginbursttransfer;
    logic [DW-1:0] avm_readdata;
    logic          avm_waitrequest, avm_readdatavalid;
    logic          busy, err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    avalon_m_burst_master #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW)) dut (
        .clk(clk), .arst(arst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_address(cmd_address), .cmd_burstcount(cmd_burstcount),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .avm_address(avm_address), .avm_byteenable(avm_byteenable),
        .avm_chipselect(avm_chipselect), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_burstcount(avm_burstcount),
        .avm_beginbursttransfer(avm_beginbursttransfer),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
        .avm_readdatavalid(avm_readdatavalid),
        .busy(busy), .err(err)
    );

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        arst = 1'b1;
        cmd_valid = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_cmd_ready got=%b exp=0", cmd_ready);
        end
        n_cmp++;
        if ({avm_read, avm_write, avm_chipselect, avm_beginbursttransfer, rd_valid, wr_ready, busy, err} !== 8'b0) begin
            n_err++; $display("FAIL reset_ctrl got=%b exp=00000000",
                {avm_read, avm_write, avm_chipselect, avm_beginbursttransfer, rd_valid, wr_ready, busy, err});
        end
        n_cmp++;
        if ({avm_address, avm_burstcount, avm_writedata, rd_data} !== '0) begin
            n_err++; $display("FAIL reset_data addr=%h bc=%h wd=%h rd=%h exp all zero",
                avm_address, avm_burstcount, avm_writedata, rd_data);
        end
        n_cmp++;
        if (avm_byteenable !== {(DW/8){1'b1}}) begin
            n_err++; $display("FAIL reset_byteenable got=%h exp=all ones", avm_byteenable);
        end
        tick();
        cmd_valid = 1'b0;
        arst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({cmd_ready, busy} !== 2'b10) begin
            n_err++; $display("FAIL reset_release got=%b exp=10", {cmd_ready, busy});
        end
        tick();
    endtask

    // waits >= 0 stalls the request exactly that many cycles; waits < 0 stalls randomly.
    task automatic run_read(input logic [AW-1:0] addr, input int n, input int waits, input bit spaced);
        bit req_open = 1'b1, first = 1'b1, prev_rdv = 1'b0, done = 1'b0;
        logic [DW-1:0] prev_dat = '0;
        int beats = 0, req_cycles = 0, dut_read_cycles = 0, rv_pulses = 0;
        logic [7:0] exp_ctrl, got_ctrl;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = addr; cmd_burstcount = BW'(n);
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL rd_cmd_accept got=%b exp=1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            if (req_open)
                avm_waitrequest = (waits >= 0) ? (req_cycles < waits) : ($urandom_range(0, 2) == 0);
            else
                avm_waitrequest = $urandom_range(0, 1) == 1;
            avm_readdatavalid = !req_open && beats < n && !(spaced && prev_rdv) && ($urandom_range(0, 1) == 1);
            avm_readdata = {$urandom, $urandom};
            @(negedge clk);
            exp_ctrl = {req_open, 1'b0, 1'b1, first, 1'b1, prev_rdv, 1'b0, 1'b0};
            got_ctrl = {avm_read, avm_write, avm_chipselect, avm_beginbursttransfer, busy, rd_valid, err, cmd_ready};
            n_cmp++;
            if (got_ctrl !== exp_ctrl) begin
                n_err++; $display("FAIL rd_ctrl cyc=%0d got=%b exp=%b", cyc, got_ctrl, exp_ctrl);
            end
            n_cmp++;
            if ({avm_address, avm_burstcount} !== {addr, BW'(n)}) begin
                n_err++; $display("FAIL rd_addr_bc got=%h/%0d exp=%h/%0d", avm_address, avm_burstcount, addr, n);
            end
            if (prev_rdv) begin
                n_cmp++;
                if (rd_data !== prev_dat) begin
                    n_err++; $display("FAIL rd_data got=%h exp=%h", rd_data, prev_dat);
                end
            end
            dut_read_cycles += int'(avm_read === 1'b1);
            rv_pulses += int'(rd_valid === 1'b1);
            if (req_open) req_cycles++;
            if (req_open && !avm_waitrequest) req_open = 1'b0;
            if (avm_readdatavalid) beats++;
            prev_rdv = avm_readdatavalid;
            prev_dat = avm_readdata;
            first = 1'b0;
            tick();
            if (beats == n) done = 1'b1;
        end
        avm_readdatavalid = 1'b0;
        avm_waitrequest = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (!done) begin
            n_err++; $display("FAIL rd_timeout beats=%0d exp=%0d", beats, n);
        end
        got_ctrl = {avm_read, avm_write, avm_chipselect, avm_beginbursttransfer, busy, rd_valid, err, cmd_ready};
        n_cmp++;
        if (got_ctrl !== 8'b00000101) begin
            n_err++; $display("FAIL rd_end_ctrl got=%b exp=00000101", got_ctrl);
        end
        n_cmp++;
        if (rd_data !== prev_dat) begin
            n_err++; $display("FAIL rd_last_data got=%h exp=%h", rd_data, prev_dat);
        end
        rv_pulses += int'(rd_valid === 1'b1);
        n_cmp++;
        if (rv_pulses != n) begin
            n_err++; $display("FAIL rd_beat_count got=%0d exp=%0d", rv_pulses, n);
        end
        if (waits >= 0) begin
            n_cmp++;
            if (dut_read_cycles != waits + 1) begin
                n_err++; $display("FAIL rd_req_cycles got=%0d exp=%0d", dut_read_cycles, waits + 1);
            end
        end
        tick();
    endtask

    // directed: gap of 2 cycles in wr_valid after beat 1, waitrequest for 2 cycles on beat 2.
    task automatic run_write(input logic [AW-1:0] addr, input int n, input bit directed);
        logic [DW-1:0] src[$];
        logic [DW-1:0] pend[$];
        int issued = 0, completed = 0, gap_left = 2, stall_left = 2, dut_beats = 0;
        bit bbt_seen = 1'b0, done = 1'b0, gap_use, stall_use, exp_wr_rdy, exp_write;
        logic [8:0] exp_ctrl, got_ctrl;
        for (int i = 0; i < n; i++) src.push_back({$urandom, $urandom});
        avm_readdatavalid = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = addr; cmd_burstcount = BW'(n);
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL wr_cmd_accept got=%b exp=1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            gap_use = directed && issued == 1 && gap_left > 0;
            stall_use = directed && pend.size() > 0 && completed == 1 && stall_left > 0;
            if (directed) begin
                wr_valid = issued < n && !gap_use;
                avm_waitrequest = stall_use;
            end else begin
                wr_valid = $urandom_range(0, 2) != 0;
                avm_waitrequest = $urandom_range(0, 1) == 1;
            end
            wr_data = (issued < n) ? src[issued] : {$urandom, $urandom};
            @(negedge clk);
            exp_write = pend.size() > 0;
            exp_wr_rdy = issued < n && (!exp_write || !avm_waitrequest);
            exp_ctrl = {1'b0, exp_write, 1'b1, exp_write && !bbt_seen, 1'b1, 1'b0, 1'b0, 1'b0, exp_wr_rdy};
            got_ctrl = {avm_read, avm_write, avm_chipselect, avm_beginbursttransfer, busy, rd_valid, err, cmd_ready, wr_ready};
            n_cmp++;
            if (got_ctrl !== exp_ctrl) begin
                n_err++; $display("FAIL wr_ctrl cyc=%0d got=%b exp=%b", cyc, got_ctrl, exp_ctrl);
            end
            n_cmp++;
            if ({avm_address, avm_burstcount} !== {addr, BW'(n)}) begin
                n_err++; $display("FAIL wr_addr_bc got=%h/%0d exp=%h/%0d", avm_address, avm_burstcount, addr, n);
            end
            if (exp_write) begin
                n_cmp++;
                if (avm_writedata !== pend[0]) begin
                    n_err++; $display("FAIL wr_data beat=%0d got=%h exp=%h", completed, avm_writedata, pend[0]);
                end
                bbt_seen = 1'b1;
            end
            dut_beats += int'(avm_write === 1'b1 && !avm_waitrequest);
            if (exp_write && !avm_waitrequest) begin
                void'(pend.pop_front());
                completed++;
            end
            if (wr_valid && exp_wr_rdy) begin
                pend.push_back(wr_data);
                issued++;
            end
            if (gap_use) gap_left--;
            if (stall_use) stall_left--;
            tick();
            if (completed == n) done = 1'b1;
        end
        wr_valid = 1'b0;
        avm_waitrequest = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (!done) begin
            n_err++; $display("FAIL wr_timeout completed=%0d exp=%0d", completed, n);
        end
        n_cmp++;
        if ({avm_write, avm_chipselect, avm_beginbursttransfer, busy, cmd_ready, wr_ready} !== 6'b000010) begin
            n_err++; $display("FAIL wr_end_ctrl got=%b exp=000010",
                {avm_write, avm_chipselect, avm_beginbursttransfer, busy, cmd_ready, wr_ready});
        end
        n_cmp++;
        if (dut_beats != n) begin
            n_err++; $display("FAIL wr_beat_count got=%0d exp=%0d", dut_beats, n);
        end
        tick();
    endtask

    task automatic test_zero_burst();
        cmd_valid = 1'b1; cmd_write = 1'($urandom_range(0, 1)); cmd_address = $urandom; cmd_burstcount = '0;
        @(negedge clk);
        n_cmp++;
        if ({cmd_ready, err} !== 2'b10) begin
            n_err++; $display("FAIL zero_accept got=%b exp=10", {cmd_ready, err});
        end
        tick();
        cmd_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({err, cmd_ready, busy, avm_read, avm_write, avm_chipselect} !== 6'b110000) begin
            n_err++; $display("FAIL zero_err_pulse got=%b exp=110000",
                {err, cmd_ready, busy, avm_read, avm_write, avm_chipselect});
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({err, cmd_ready, avm_read, avm_write} !== 4'b0100) begin
            n_err++; $display("FAIL zero_err_clear got=%b exp=0100", {err, cmd_ready, avm_read, avm_write});
        end
        tick();
    endtask

    task automatic test_stray_rdv();
        avm_readdatavalid = 1'b1; avm_readdata = {$urandom, $urandom};
        tick();
        avm_readdatavalid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({rd_valid, err, busy} !== 3'b010) begin
            n_err++; $display("FAIL stray_pulse got=%b exp=010", {rd_valid, err, busy});
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({rd_valid, err} !== 2'b00) begin
            n_err++; $display("FAIL stray_clear got=%b exp=00", {rd_valid, err});
        end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        logic [AW-1:0] a = $urandom;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = a; cmd_burstcount = 4'd4;
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        avm_readdatavalid = 1'b1;
        repeat (2) begin
            avm_readdata = {$urandom, $urandom};
            tick();
        end
        avm_readdatavalid = 1'b0;
        arst = 1'b1;
        tick();
        arst = 1'b0;
        avm_readdatavalid = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({avm_read, avm_write, avm_chipselect, avm_beginbursttransfer, rd_valid, wr_ready, busy, err, cmd_ready} !== 9'b000000001) begin
            n_err++; $display("FAIL mid_reset_ctrl got=%b exp=000000001",
                {avm_read, avm_write, avm_chipselect, avm_beginbursttransfer, rd_valid, wr_ready, busy, err, cmd_ready});
        end
        n_cmp++;
        if ({avm_address, avm_burstcount, avm_writedata, rd_data} !== '0) begin
            n_err++; $display("FAIL mid_reset_data addr=%h bc=%h rd=%h exp zero", avm_address, avm_burstcount, rd_data);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({rd_valid, err, busy} !== 3'b010) begin
            n_err++; $display("FAIL mid_reset_late_beat got=%b exp=010", {rd_valid, err, busy});
        end
        tick();
        avm_readdatavalid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({rd_valid, err} !== 2'b01) begin
            n_err++; $display("FAIL mid_reset_late_beat2 got=%b exp=01", {rd_valid, err});
        end
        tick();
        run_read($urandom, 2, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] rdat = {$urandom, $urandom};
        logic [DW-1:0] wdat = {$urandom, $urandom};
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; wr_valid = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 32'h300; cmd_burstcount = 4'd1;
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL b2b_first_accept got=%b exp=1", cmd_ready);
        end
        tick();
        cmd_write = 1'b1; cmd_address = 32'h400;
        @(negedge clk);
        n_cmp++;
        if ({avm_read, avm_write, avm_beginbursttransfer, cmd_ready} !== 4'b1010) begin
            n_err++; $display("FAIL b2b_rd_req got=%b exp=1010", {avm_read, avm_write, avm_beginbursttransfer, cmd_ready});
        end
        tick();
        avm_readdatavalid = 1'b1; avm_readdata = rdat;
        @(negedge clk);
        n_cmp++;
        if ({avm_read, avm_write, cmd_ready} !== 3'b000) begin
            n_err++; $display("FAIL b2b_rd_data got=%b exp=000", {avm_read, avm_write, cmd_ready});
        end
        tick();
        avm_readdatavalid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({rd_valid, cmd_ready, avm_read, avm_write} !== 4'b1100 || rd_data !== rdat) begin
            n_err++; $display("FAIL b2b_handover got=%b/%h exp=1100/%h", {rd_valid, cmd_ready, avm_read, avm_write}, rd_data, rdat);
        end
        tick();
        cmd_valid = 1'b0;
        wr_valid = 1'b1; wr_data = wdat;
        @(negedge clk);
        n_cmp++;
        if ({wr_ready, avm_write, avm_read, avm_chipselect, busy} !== 5'b10011 || avm_address !== 32'h400) begin
            n_err++; $display("FAIL b2b_wr_start got=%b/%h exp=10011/400", {wr_ready, avm_write, avm_read, avm_chipselect, busy}, avm_address);
        end
        tick();
        wr_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({avm_write, avm_read, avm_beginbursttransfer} !== 3'b101 || avm_writedata !== wdat) begin
            n_err++; $display("FAIL b2b_wr_beat got=%b/%h exp=101/%h", {avm_write, avm_read, avm_beginbursttransfer}, avm_writedata, wdat);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({avm_write, avm_read, avm_chipselect, busy, cmd_ready} !== 5'b00001) begin
            n_err++; $display("FAIL b2b_end got=%b exp=00001", {avm_write, avm_read, avm_chipselect, busy, cmd_ready});
        end
        tick();
    endtask

    task automatic test_random();
        run_read($urandom, 15, -1, 1'b0);
        run_write($urandom, 15, 1'b0);
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 1) == 1)
                run_read($urandom, $urandom_range(1, 15), -1, 1'b0);
            else
                run_write($urandom, $urandom_range(1, 15), 1'b0);
        end
    endtask

    initial begin
        arst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0; cmd_burstcount = '0;
        wr_data = '0; wr_valid = 1'b0; avm_readdata = '0; avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
        test_reset();
        run_read(32'h100, 4, 2, 1'b1);
        run_write(32'h200, 3, 1'b1);
        test_zero_burst();
        test_stray_rdv();
        test_reset_mid_burst();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
